// File: rtl/gpio_bus_pkg.sv
// gpio_bus_pkg: register map, status codes and state types shared by
// masters of the gpioemu register bus.
package gpio_bus_pkg;

    localparam logic [15:0] GPIO_ADDR_A = 16'h00D4;
    localparam logic [15:0] GPIO_ADDR_W = 16'h00E4;
    localparam logic [15:0] GPIO_ADDR_S = 16'h00EC;

    localparam logic [31:0] S_BUSY = 32'h0000_00CC;
    localparam logic [31:0] S_IDLE = 32'h0000_0000;

    localparam int SETUP_CYC   = 1;
    localparam int STROBE_CYC  = 1;
    localparam int SAMPLE_CYC  = 1;
    localparam int XFER_WR_CYC = SETUP_CYC + STROBE_CYC;
    localparam int XFER_RD_CYC = SETUP_CYC + STROBE_CYC + SAMPLE_CYC;

    localparam int WAIT_W = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_SETUP,
        ST_WR_STB,
        ST_SETTLE,
        ST_P_SETUP,
        ST_P_STB,
        ST_P_SAMP,
        ST_P_GAP,
        ST_R_SETUP,
        ST_R_STB,
        ST_R_SAMP,
        ST_RESP
    } host_state_e;

    typedef enum logic [1:0] {
        XF_IDLE,
        XF_SETUP,
        XF_STROBE,
        XF_SAMPLE
    } xfer_phase_e;

endpackage

// File: rtl/gpio_prime_host_if.sv
// gpio_prime_host_if: client request/response channels plus the
// gpioemu register bus, grouped for the host sequencer.
interface gpio_prime_host_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_n;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_timeout;
    logic        busy;

    logic [15:0] saddress;
    logic        srd;
    logic        swr;
    logic [31:0] sdata_in;
    logic [31:0] sdata_out;

    modport master (
        input  req_valid,
        input  req_n,
        input  resp_ready,
        input  sdata_out,
        output req_ready,
        output resp_valid,
        output resp_data,
        output resp_timeout,
        output busy,
        output saddress,
        output srd,
        output swr,
        output sdata_in
    );

    modport slave (
        output req_valid,
        output req_n,
        output resp_ready,
        output sdata_out,
        input  req_ready,
        input  resp_valid,
        input  resp_data,
        input  resp_timeout,
        input  busy,
        input  saddress,
        input  srd,
        input  swr,
        input  sdata_in
    );

endinterface

// File: rtl/gpio_bus_xfer.sv
// gpio_bus_xfer: one setup/strobe(/sample) transaction on the gpioemu bus.
// Address and write data stay latched until the next start.
module gpio_bus_xfer
    import gpio_bus_pkg::*;
(
    input  logic        clk,
    input  logic        n_reset,
    input  logic        start,
    input  logic        rd_nwr,
    input  logic [15:0] addr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic [15:0] saddress,
    output logic        srd,
    output logic        swr,
    output logic [31:0] sdata_in,
    input  logic [31:0] sdata_out
);

    xfer_phase_e phase_q;
    xfer_phase_e phase_d;
    logic        rd_q;

    always_comb begin
        phase_d = phase_q;
        unique case (phase_q)
            XF_IDLE:    phase_d = XF_IDLE;
            XF_SETUP:   phase_d = XF_STROBE;
            XF_STROBE:  phase_d = rd_q ? XF_SAMPLE : XF_IDLE;
            XF_SAMPLE:  phase_d = XF_IDLE;
            default:    phase_d = XF_IDLE;
        endcase
        if (start) begin
            phase_d = XF_SETUP;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            phase_q  <= XF_IDLE;
            rd_q     <= 1'b0;
            saddress <= '0;
            sdata_in <= '0;
            srd      <= 1'b0;
            swr      <= 1'b0;
        end else begin
            phase_q <= phase_d;
            // strobe lives exactly in the STROBE phase
            srd <= (phase_q == XF_SETUP) && rd_q;
            swr <= (phase_q == XF_SETUP) && !rd_q;
            if (start) begin
                rd_q     <= rd_nwr;
                saddress <= addr;
                if (!rd_nwr) begin
                    sdata_in <= wdata;
                end
            end
        end
    end

    assign done  = ((phase_q == XF_STROBE) && !rd_q) ||
                   (phase_q == XF_SAMPLE);
    assign rdata = sdata_out;

endmodule

// File: rtl/gpio_prime_host.sv
// gpio_prime_host: writes a prime index to gpioemu, polls status until
// the computation ends (or times out) and returns the result word.
module gpio_prime_host
    import gpio_bus_pkg::*;
#(
    parameter logic [15:0] ADDR_A      = GPIO_ADDR_A,
    parameter logic [15:0] ADDR_W      = GPIO_ADDR_W,
    parameter logic [15:0] ADDR_S      = GPIO_ADDR_S,
    parameter logic [31:0] BUSY_CODE   = S_BUSY,
    parameter int          SETTLE_CYC  = 4,
    parameter int          POLL_GAP    = 16,
    parameter int unsigned TIMEOUT_CYC = 1048576
)
(
    input  logic              clk,
    input  logic              n_reset,
    gpio_prime_host_if.master bus
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    host_state_e state_q;
    host_state_e state_d;

    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;
    logic [TMO_W-1:0]  tmo_q;
    logic [TMO_W-1:0]  tmo_d;
    logic [TMO_W-1:0]  tmo_inc;
    logic              tmo_expired;

    logic        req_ready_q;
    logic        busy_q;
    logic        resp_valid_q;
    logic [31:0] resp_data_q;
    logic        resp_timeout_q;

    logic        accept;
    logic        capture;
    logic        tmo_hit;

    logic        x_start;
    logic        x_rd;
    logic [15:0] x_addr;
    logic [31:0] x_wdata;
    logic        x_done;
    logic [31:0] x_rdata;

    assign tmo_inc     = (tmo_q == '1) ? tmo_q : tmo_q + 1'b1;
    assign tmo_expired = tmo_q >= TMO_W'(TIMEOUT_CYC);

    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        tmo_d   = '0;
        accept  = 1'b0;
        capture = 1'b0;
        tmo_hit = 1'b0;
        x_start = 1'b0;
        x_rd    = 1'b1;
        x_addr  = ADDR_S;
        x_wdata = bus.req_n;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    accept = 1'b1;
                    if (bus.req_n == '0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WR_SETUP;
                        x_start = 1'b1;
                        x_rd    = 1'b0;
                        x_addr  = ADDR_A;
                    end
                end
            end
            ST_WR_SETUP: state_d = ST_WR_STB;
            ST_WR_STB: begin
                if (x_done) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (wait_q == WAIT_W'(SETTLE_CYC - 1)) begin
                    state_d = ST_P_SETUP;
                    x_start = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_P_SETUP: begin
                tmo_d   = tmo_inc;
                state_d = ST_P_STB;
            end
            ST_P_STB: begin
                tmo_d   = tmo_inc;
                state_d = ST_P_SAMP;
            end
            ST_P_SAMP: begin
                tmo_d = tmo_inc;
                if (x_done) begin
                    if (x_rdata != BUSY_CODE) begin
                        state_d = ST_R_SETUP;
                        x_start = 1'b1;
                        x_addr  = ADDR_W;
                    end else if (tmo_expired) begin
                        state_d = ST_RESP;
                        tmo_hit = 1'b1;
                    end else begin
                        state_d = ST_P_GAP;
                    end
                end
            end
            ST_P_GAP: begin
                tmo_d = tmo_inc;
                // abort only between polls so no strobe is cut short
                if (tmo_expired) begin
                    state_d = ST_RESP;
                    tmo_hit = 1'b1;
                end else if (wait_q == WAIT_W'(POLL_GAP - 1)) begin
                    state_d = ST_P_SETUP;
                    x_start = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_R_SETUP: state_d = ST_R_STB;
            ST_R_STB:   state_d = ST_R_SAMP;
            ST_R_SAMP: begin
                if (x_done) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q        <= ST_IDLE;
            wait_q         <= '0;
            tmo_q          <= '0;
            req_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_data_q    <= '0;
            resp_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            tmo_q        <= tmo_d;
            req_ready_q  <= state_d == ST_IDLE;
            busy_q       <= state_d != ST_IDLE;
            resp_valid_q <= state_d == ST_RESP;
            if (accept) begin
                resp_data_q    <= '0;
                resp_timeout_q <= 1'b0;
            end else if (capture) begin
                resp_data_q <= x_rdata;
            end else if (tmo_hit) begin
                resp_timeout_q <= 1'b1;
            end
        end
    end

    gpio_bus_xfer u_xfer (
        .clk       (clk),
        .n_reset   (n_reset),
        .start     (x_start),
        .rd_nwr    (x_rd),
        .addr      (x_addr),
        .wdata     (x_wdata),
        .done      (x_done),
        .rdata     (x_rdata),
        .saddress  (bus.saddress),
        .srd       (bus.srd),
        .swr       (bus.swr),
        .sdata_in  (bus.sdata_in),
        .sdata_out (bus.sdata_out)
    );

    assign bus.req_ready    = req_ready_q;
    assign bus.busy         = busy_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_data    = resp_data_q;
    assign bus.resp_timeout = resp_timeout_q;

endmodule

// File: tb/tb_gpio_prime_host.sv
// tb_gpio_prime_host: directed bench with a gpioemu stub slave and a
// bus-protocol monitor.
module tb_gpio_prime_host;
    import gpio_bus_pkg::*;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    always #5 clk = ~clk;

    gpio_prime_host_if bus();

    gpio_prime_host #(.TIMEOUT_CYC(64)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // gpioemu stub: busy for busy_init cycles after an A write
    logic [31:0] reg_a = '0;
    logic [31:0] rd_q = '0;
    int busy_left = 0;
    int busy_init = 0;
    bit stuck = 1'b0;

    function automatic logic [31:0] nth_prime(input logic [31:0] n);
        case (n)
            32'd15:   return 32'd47;
            32'd24:   return 32'd89;
            32'd1000: return 32'd7919;
            default:  return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus.swr && bus.saddress == 16'h00D4) begin
            reg_a     <= bus.sdata_in;
            busy_left <= busy_init;
        end else if (busy_left > 0) begin
            busy_left <= busy_left - 1;
        end
        if (bus.srd) begin
            case (bus.saddress)
                16'h00EC: rd_q <= (stuck || busy_left > 0) ? 32'h0000_00CC : S_IDLE;
                16'h00E4: rd_q <= nth_prime(reg_a);
                16'h00D4: rd_q <= reg_a;
                default:  rd_q <= 32'hDEAD_BEEF;
            endcase
        end
    end
    assign bus.sdata_out = rd_q;

    int n_swr = 0, n_srd = 0, n_wr_a = 0, n_rd_s = 0, n_rd_w = 0;
    int overlap_err = 0, width_err = 0, stab_err = 0;
    logic [31:0] last_wdata = '0;
    logic p_srd = 1'b0, p_swr = 1'b0, s1 = 1'b0;
    logic [15:0] a1 = '0, a2 = '0;
    logic [31:0] d1 = '0, d2 = '0;

    always @(negedge clk) begin
        if (n_reset) begin
            if (bus.srd && bus.swr) overlap_err++;
            if ((bus.srd && p_srd) || (bus.swr && p_swr)) width_err++;
            if (bus.swr) begin
                n_swr++;
                last_wdata = bus.sdata_in;
                if (bus.saddress == 16'h00D4) n_wr_a++;
            end
            if (bus.srd) begin
                n_srd++;
                if (bus.saddress == 16'h00EC) n_rd_s++;
                if (bus.saddress == 16'h00E4) n_rd_w++;
            end
            if (s1 && (bus.saddress != a1 || a1 != a2 ||
                       bus.sdata_in != d1 || d1 != d2)) stab_err++;
            a2 = a1; a1 = bus.saddress;
            d2 = d1; d1 = bus.sdata_in;
            s1 = bus.srd | bus.swr;
            p_srd = bus.srd; p_swr = bus.swr;
        end
    end

    task automatic run_req(input logic [31:0] n, output int lat,
                           output logic busy1);
        int g;
        @(negedge clk);
        bus.req_n = n;
        bus.req_valid = 1'b1;
        g = 0;
        while (!bus.req_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("req_ready_before_req", bus.req_ready, 1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        busy1 = bus.busy;
        lat = 1;
        while (!bus.resp_valid && lat < 3000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("resp_valid_seen", bus.resp_valid, 1);
    endtask

    task automatic ack();
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        check("resp_valid_drop", bus.resp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int s_swr, s_wra, s_srd, s_rds, s_rdw;
        int hold_bad, ign_bad, g;
        logic b1;

        bus.req_valid  = 1'b0;
        bus.req_n      = '0;
        bus.resp_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_timeout", bus.resp_timeout, 0);
        check("rst_resp_data", bus.resp_data, 0);
        check("rst_saddress", bus.saddress, 0);
        check("rst_sdata_in", bus.sdata_in, 0);
        check("rst_strobes", {bus.srd, bus.swr}, 0);
        @(negedge clk);
        n_reset = 1'b1;

        // n=0x18 with a slow computation
        busy_init = 30;
        s_swr = n_swr; s_wra = n_wr_a; s_rds = n_rd_s; s_rdw = n_rd_w;
        run_req(32'h18, lat, b1);
        check("n18_busy", b1, 1);
        check("n18_data", bus.resp_data, 32'h59);
        check("n18_timeout", bus.resp_timeout, 0);
        check("n18_one_swr", n_swr - s_swr, 1);
        check("n18_swr_at_a", n_wr_a - s_wra, 1);
        check("n18_wdata", last_wdata, 32'h18);
        check("n18_multi_poll", (n_rd_s - s_rds) >= 2, 1);
        check("n18_one_w_read", n_rd_w - s_rdw, 1);
        ack();

        // n=0x3E8, S done at first poll: minimum latency
        busy_init = 0;
        run_req(32'h3E8, lat, b1);
        check("n3e8_latency", lat, 13);
        check("n3e8_data", bus.resp_data, 32'h1EEF);
        check("n3e8_timeout", bus.resp_timeout, 0);
        ack();

        // n=0: no bus traffic, one-cycle response
        s_swr = n_swr; s_srd = n_srd;
        run_req(32'h0, lat, b1);
        check("n0_latency", lat, 1);
        check("n0_data", bus.resp_data, 0);
        check("n0_timeout", bus.resp_timeout, 0);
        check("n0_no_swr", n_swr - s_swr, 0);
        check("n0_no_srd", n_srd - s_srd, 0);
        ack();

        // n=0xF with resp_ready held low and a second request pending
        busy_init = 10;
        run_req(32'hF, lat, b1);
        @(negedge clk);
        bus.req_n = 32'h18;
        bus.req_valid = 1'b1;
        hold_bad = 0;
        ign_bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (!bus.resp_valid || bus.resp_data != 32'h2F) hold_bad++;
            if (bus.req_ready || !bus.busy) ign_bad++;
        end
        check("nf_hold_stable", hold_bad, 0);
        check("nf_req_ignored", ign_bad, 0);
        check("nf_data", bus.resp_data, 32'h2F);
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        check("hs_resp_valid", bus.resp_valid, 0);
        check("hs_not_accepted", bus.busy, 0);
        check("hs_req_ready", bus.req_ready, 1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("hs_accept_next", bus.busy, 1);
        g = 0;
        while (!bus.resp_valid && g < 3000) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("second_resp_seen", bus.resp_valid, 1);
        check("second_data", bus.resp_data, 32'h59);
        ack();

        // status stuck busy: timeout, W never read
        stuck = 1'b1;
        s_rdw = n_rd_w;
        run_req(32'h18, lat, b1);
        check("tmo_flag", bus.resp_timeout, 1);
        check("tmo_data", bus.resp_data, 0);
        check("tmo_no_w_read", n_rd_w - s_rdw, 0);
        ack();
        stuck = 1'b0;

        check("no_overlap", overlap_err, 0);
        check("no_wide_strobe", width_err, 0);
        check("addr_data_stable", stab_err, 0);

        // reset pulse during the write strobe
        s_swr = n_swr;
        @(negedge clk);
        bus.req_n = 32'h18;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("wrstb_swr", bus.swr, 1);
        check("wrstb_addr", bus.saddress, 32'hD4);
        check("wrstb_data", bus.sdata_in, 32'h18);
        #1;
        n_reset = 1'b0;
        #1;
        check("rst_mid_swr", bus.swr, 0);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_resp_valid", bus.resp_valid, 0);
        check("rst_mid_req_ready", bus.req_ready, 1);
        @(negedge clk);
        n_reset = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("post_rst_req_ready", bus.req_ready, 1);
        check("post_rst_busy", bus.busy, 0);
        check("post_rst_no_retry", n_swr - s_swr, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
